mem_sp_banked_sky130: RTL and testbench



---
 rtl/mem_sp_banked_sky130_pkg.sv | 16 +
 rtl/mem_sp_banked_sky130_if.sv | 24 ++
 rtl/mem_sp_banked_sky130_tile_row.sv | 30 +++
 rtl/sky130_sram_0kbytes_1rw_32x128_32.sv | 22 ++
 rtl/mem_sp_banked_sky130.sv | 128 ++++++++++++
 tb/tb_mem_sp_banked_sky130.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/mem_sp_banked_sky130_pkg.sv
// Shared constants and types for the banked sky130 SRAM wrapper.
// The macro geometry is fixed by the sky130_sram_0kbytes_1rw_32x128_32 hard macro.
package mem_sky130_pkg;

    localparam int MACRO_WIDTH  = 32;
    localparam int MACRO_DEPTH  = 128;
    localparam int MACRO_ADDR_W = 8;
    localparam int LOCAL_W      = $clog2(MACRO_DEPTH);

    typedef enum logic {IDLE, RMW} mem_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mem_sp_banked_sky130_if.sv
// Request/response bundle between an accelerator buffer and the SRAM wrapper.
interface mem_sp_banked_sky130_if #(
    parameter int DATA_BIT = 64,
    parameter int ADDR_BIT = 9
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wen;
    logic [ADDR_BIT-1:0] req_addr;
    logic [DATA_BIT-1:0] req_bwe;
    logic [DATA_BIT-1:0] req_wdata;
    logic                rsp_valid;
    logic [DATA_BIT-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_bwe, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_bwe, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_sp_banked_sky130_tile_row.sv
// One depth tile: NUM_BANKS macros side by side sharing address and control.
// With use_mask set, a bank whose mask slice is all zero stays deselected.
module mem_sky130_tile_row
    import mem_sky130_pkg::*;
#(
    parameter int NUM_BANKS = 2
) (
    input  logic                             clk,
    input  logic                             en,
    input  logic                             we,
    input  logic                             use_mask,
    input  logic [LOCAL_W-1:0]               addr,
    input  logic [NUM_BANKS*MACRO_WIDTH-1:0] mask,
    input  logic [NUM_BANKS*MACRO_WIDTH-1:0] din,
    output logic [NUM_BANKS*MACRO_WIDTH-1:0] dout
);
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel;
        assign sel = en & (~use_mask | (|mask[b*MACRO_WIDTH +: MACRO_WIDTH]));

        sky130_sram_0kbytes_1rw_32x128_32 u_macro (
            .clk0  (clk),
            .csb0  (~sel),
            .web0  (~we),
            .addr0 (MACRO_ADDR_W'(addr)),
            .din0  (din[b*MACRO_WIDTH +: MACRO_WIDTH]),
            .dout0 (dout[b*MACRO_WIDTH +: MACRO_WIDTH])
        );
    end
endmodule

// File: rtl/sky130_sram_0kbytes_1rw_32x128_32.sv
// Behavioural stand-in for the 32x128 single-port sky130 macro: registered read
// on a selected non-write cycle; dout holds across deselected and write cycles.
module sky130_sram_0kbytes_1rw_32x128_32 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0
);
    logic [31:0] mem [128];
    logic        unused_addr;

    assign unused_addr = addr0[7];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[addr0[6:0]] <= din0;
            else       dout0 <= mem[addr0[6:0]];
        end
    end
endmodule

// File: rtl/mem_sp_banked_sky130.sv
// Banked single-port SRAM wrapper: valid/ready requests, 2-edge read latency,
// bit-masked writes done as a 2-cycle read-modify-write.
module mem_sp_banked_sky130
    import mem_sky130_pkg::*;
#(
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 512,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter bit BWE      = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    mem_sp_banked_sky130_if.slave bus
);
    localparam int NUM_BANKS = ceil_div(DATA_BIT, MACRO_WIDTH);
    localparam int NUM_TILES = ceil_div(DEPTH, MACRO_DEPTH);
    localparam int PAD_W     = NUM_BANKS * MACRO_WIDTH;
    // Tiling only makes sense with more than one macro of depth.
    localparam int TILE_W    = ADDR_BIT - LOCAL_W;

    mem_state_t                      state, state_nxt;
    logic                            acc, in_range, wr_full, wr_none, wr_part;
    logic [LOCAL_W-1:0]              addr_local, rmw_local, tile_addr;
    logic [TILE_W-1:0]               addr_tile, rmw_tile, rd_tile, tile_sel;
    logic [DATA_BIT-1:0]             rmw_bwe, rmw_wdata, merged;
    logic [2:1]                      vld_pipe;
    logic                            rd_issue, rd_oor;
    logic                            tile_go, tile_we, tile_use_mask;
    logic [NUM_TILES-1:0]            tile_en;
    logic [PAD_W-1:0]                tile_mask, tile_din, rd_dout, rmw_dout;
    logic [NUM_TILES-1:0][PAD_W-1:0] tile_dout;

    assign addr_local    = bus.req_addr[LOCAL_W-1:0];
    assign addr_tile     = bus.req_addr[ADDR_BIT-1:LOCAL_W];
    assign in_range      = int'(bus.req_addr) < DEPTH;
    assign bus.req_ready = ~rst & (state == IDLE);
    assign acc           = bus.req_valid & bus.req_ready;
    assign wr_full       = !BWE || (&bus.req_bwe);
    assign wr_none       = BWE && !(|bus.req_bwe);
    assign wr_part       = !wr_full && !wr_none;
    assign rd_issue      = acc & ~bus.req_wen;
    assign tile_sel      = (state == RMW) ? rmw_tile : addr_tile;

    assign rmw_dout = tile_dout[rmw_tile];
    assign rd_dout  = tile_dout[rd_tile];
    assign merged   = (rmw_dout[DATA_BIT-1:0] & ~rmw_bwe) | (rmw_wdata & rmw_bwe);

    always_comb begin
        state_nxt     = state;
        tile_go       = 1'b0;
        tile_we       = 1'b0;
        tile_use_mask = 1'b0;
        tile_addr     = addr_local;
        tile_din      = PAD_W'(bus.req_wdata);
        tile_mask     = '0;
        unique case (state)
            IDLE: begin
                // A partial write starts with a plain read of the whole word.
                if (acc && in_range && !(bus.req_wen && wr_none)) begin
                    tile_go = 1'b1;
                    tile_we = bus.req_wen && wr_full;
                    if (bus.req_wen && wr_part) state_nxt = RMW;
                end
            end
            RMW: begin
                tile_go       = 1'b1;
                tile_we       = 1'b1;
                tile_use_mask = 1'b1;
                tile_addr     = rmw_local;
                tile_din      = PAD_W'(merged);
                tile_mask     = PAD_W'(rmw_bwe);
                state_nxt     = IDLE;
            end
        endcase
        if (rst) begin
            tile_go   = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TILES; t++)
            tile_en[t] = tile_go && (tile_sel == TILE_W'(t));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            vld_pipe      <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[1], rd_issue};
            if (vld_pipe[1]) bus.rsp_rdata <= rd_oor ? '0 : rd_dout[DATA_BIT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            rd_tile   <= in_range ? addr_tile : '0;
            rd_oor    <= !in_range;
            rmw_tile  <= addr_tile;
            rmw_local <= addr_local;
            rmw_bwe   <= bus.req_bwe;
            rmw_wdata <= bus.req_wdata;
        end
    end

    assign bus.rsp_valid = vld_pipe[2];

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        mem_sky130_tile_row #(.NUM_BANKS(NUM_BANKS)) u_row (
            .clk      (clk),
            .en       (tile_en[t]),
            .we       (tile_we),
            .use_mask (tile_use_mask),
            .addr     (tile_addr),
            .mask     (tile_mask),
            .din      (tile_din),
            .dout     (tile_dout[t])
        );
    end

    if (PAD_W > DATA_BIT) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{rd_dout[PAD_W-1:DATA_BIT], rmw_dout[PAD_W-1:DATA_BIT]};
    end
endmodule

// File: tb/tb_mem_sp_banked_sky130.sv
// Bench for the banked SRAM wrapper: directed table, corner sequences, and random
// traffic against a word-level memory model; a second instance covers odd geometry.
module tb_mem_sp_banked_sky130;
    localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_sp_banked_sky130_if #(.DATA_BIT(64), .ADDR_BIT(9)) bus ();
    mem_sp_banked_sky130_if #(.DATA_BIT(40), .ADDR_BIT(9)) bus2 ();

    mem_sp_banked_sky130 #(.DATA_BIT(64), .DEPTH(512), .ADDR_BIT(9), .BWE(1'b1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    mem_sp_banked_sky130 #(.DATA_BIT(40), .DEPTH(384), .ADDR_BIT(9), .BWE(1'b1)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    typedef struct { int due; logic [63:0] data; } exp_t;
    typedef struct {
        logic        wen;
        logic [8:0]  addr;
        logic [63:0] bwe;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    logic [63:0] ref_mem [512];
    exp_t        exp_q[$];
    int          cyc, n_cmp, n_bad;
    logic        rmw_busy;
    logic [8:0]  rmw_addr;
    logic [63:0] rmw_m, rmw_d;
    logic        last_v;
    logic [63:0] last_d;
    vec_t        vecs [12];
    logic [8:0]  pool [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // One clock of traffic on the 64-bit instance; the model decides acceptance,
    // memory effects and when each read response is due.
    task automatic cycle(input logic v, input logic w, input logic [8:0] a,
                         input logic [63:0] m, input logic [63:0] d);
        logic acc, exp_v;
        bus.req_valid = v; bus.req_wen = w; bus.req_addr = a;
        bus.req_bwe = m;   bus.req_wdata = d;
        #1;
        check("req_ready", 64'(bus.req_ready), 64'(!rst && !rmw_busy));
        acc = v && !rst && !rmw_busy;
        @(posedge clk);
        cyc++;
        if (rst) begin
            rmw_busy = 1'b0;
            exp_q.delete();
        end else begin
            if (rmw_busy) begin
                ref_mem[rmw_addr] = (ref_mem[rmw_addr] & ~rmw_m) | (rmw_d & rmw_m);
                rmw_busy = 1'b0;
            end
            if (acc) begin
                if (!w)          exp_q.push_back('{cyc + 1, ref_mem[a]});
                else if (&m)     ref_mem[a] = d;
                else if (|m) begin
                    rmw_busy = 1'b1; rmw_addr = a; rmw_m = m; rmw_d = d;
                end
            end
        end
        @(negedge clk);
        #1;
        last_v = bus.rsp_valid;
        last_d = bus.rsp_rdata;
        if (rst) begin
            check("reset rsp_valid", 64'(last_v), 64'd0);
            check("reset rsp_rdata", last_d, 64'd0);
        end else begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("rsp_valid", 64'(last_v), 64'(exp_v));
            if (exp_v) begin
                check("rsp_rdata", last_d, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 9'h0, 64'h0, 64'h0);
    endtask

    task automatic op2(input string name, input logic w, input logic [8:0] a,
                       input logic [39:0] d, input logic [39:0] exp);
        check({name, " ready"}, 64'(bus2.req_ready), 64'd1);
        bus2.req_valid = 1'b1; bus2.req_wen = w; bus2.req_addr = a;
        bus2.req_bwe = '1;     bus2.req_wdata = d;
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, " rsp_valid"}, 64'(bus2.rsp_valid), 64'(!w));
        if (!w) check({name, " rsp_rdata"}, 64'(bus2.rsp_rdata), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] m;
        cyc = 0; n_cmp = 0; n_bad = 0; rmw_busy = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_wen = 1'b0; bus2.req_addr = '0;
        bus2.req_bwe = '0; bus2.req_wdata = '0;

        vecs[0]  = '{1'b1, 9'h1FF, FULL, 64'hDEAD_BEEF_0123_4567, 64'h0};
        vecs[1]  = '{1'b0, 9'h1FF, 64'h0, 64'h0, 64'hDEAD_BEEF_0123_4567};
        vecs[2]  = '{1'b1, 9'h07F, FULL, 64'hAAAA_0000_0000_007F, 64'h0};
        vecs[3]  = '{1'b1, 9'h080, FULL, 64'hBBBB_0000_0000_0080, 64'h0};
        vecs[4]  = '{1'b1, 9'h100, FULL, 64'hCCCC_0000_0000_0100, 64'h0};
        vecs[5]  = '{1'b1, 9'h0A0, FULL, 64'h1111_2222_3333_4444, 64'h0};
        vecs[6]  = '{1'b1, 9'h0A0, 64'h0000_0000_FFFF_0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0};
        vecs[7]  = '{1'b0, 9'h0A0, 64'h0, 64'h0, 64'h1111_2222_AAAA_4444};
        vecs[8]  = '{1'b1, 9'h0A0, 64'h0, FULL, 64'h0};
        vecs[9]  = '{1'b0, 9'h0A0, 64'h0, 64'h0, 64'h1111_2222_AAAA_4444};
        vecs[10] = '{1'b1, 9'h000, 64'hFF00_0000_0000_00FF, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0};
        vecs[11] = '{1'b1, 9'h000, FULL, 64'h0123_4567_89AB_CDEF, 64'h0};

        // Reset held for three edges, then released.
        rst = 1'b1;
        repeat (3) idle();
        rst = 1'b0;
        idle();

        // Directed table; each op is followed by one idle cycle in which the read returns.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, vecs[i].wen, vecs[i].addr, vecs[i].bwe, vecs[i].wdata);
            idle();
            if (!vecs[i].wen) begin
                check($sformatf("vec%0d rsp_valid", i), 64'(last_v), 64'd1);
                check($sformatf("vec%0d rdata", i), last_d, vecs[i].exp);
            end
        end
        cycle(1'b0, 1'b0, 9'h0, 64'h0, 64'h0);

        // Back-to-back reads across tile boundaries.
        cycle(1'b1, 1'b0, 9'h07F, 64'h0, 64'h0);
        cycle(1'b1, 1'b0, 9'h080, 64'h0, 64'h0);
        check("b2b A", last_d, 64'hAAAA_0000_0000_007F);
        cycle(1'b1, 1'b0, 9'h100, 64'h0, 64'h0);
        check("b2b B", last_d, 64'hBBBB_0000_0000_0080);
        idle();
        check("b2b C", last_d, 64'hCCCC_0000_0000_0100);
        check("b2b C valid", 64'(last_v), 64'd1);
        idle();

        // Partial write whose merge cycle is hit by reset.
        cycle(1'b1, 1'b1, 9'h0A0, FULL, 64'h1111_2222_3333_4444);
        cycle(1'b1, 1'b1, 9'h0A0, 64'h0000_0000_FFFF_0000, 64'hAAAA_AAAA_AAAA_AAAA);
        check("rmw ready low", 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        cycle(1'b1, 1'b0, 9'h0A0, 64'h0, 64'h0);
        idle();
        check("rmw abort rdata", last_d, 64'h1111_2222_3333_4444);
        idle();

        // Random traffic over a small address pool, with occasional reset pulses.
        pool = '{9'h000, 9'h07F, 9'h080, 9'h0A0, 9'h0FF, 9'h100, 9'h17F, 9'h1FF};
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1, pool[i], FULL, {$urandom, $urandom});
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       m = FULL;
                1:       m = 64'h0;
                2:       m = {$urandom, $urandom};
                default: m = 64'hFFFF << (16 * $urandom_range(0, 3));
            endcase
            rst = ($urandom_range(0, 59) == 0);
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  pool[$urandom_range(0, 7)], m, {$urandom, $urandom});
        end
        rst = 1'b0;
        repeat (3) idle();
        check("drain", 64'(exp_q.size()), 64'd0);

        // Narrow, non-power-of-two geometry instance.
        op2("oor write", 1'b1, 9'h1A0, 40'hFF_FFFF_FFFF, 40'h0);
        op2("oor read", 1'b0, 9'h1A0, 40'h0, 40'h0);
        op2("last write", 1'b1, 9'h17F, 40'hFF_FFFF_FFFF, 40'h0);
        op2("last read", 1'b0, 9'h17F, 40'h0, 40'hFF_FFFF_FFFF);
        op2("tile2 write", 1'b1, 9'h100, 40'h12_3456_789A, 40'h0);
        op2("tile2 read", 1'b0, 9'h100, 40'h0, 40'h12_3456_789A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
